// File: rtl/rlc_pio_pkg.sv
// Shared constants for the RLC Avalon-MM PIO blocks: register map,
// edge-capture modes and a constant-evaluable clog2 helper.
package rlc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Ceiling log2; clog2(1) is 0 so a single-cycle debounce still gets a 1-bit counter.
  function automatic int clog2(input int value);
    int v;
    int result;
    v      = value - 1;
    result = 0;
    while (v > 0) begin
      v      = v >> 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rlc_debounce_bit.sv
// One input bit: multi-flop synchroniser followed by a stable-count debouncer.
// sync_o is the synchronised raw level, stable_o the debounced level.
module rlc_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync_o,
  output logic stable_o
);
  import rlc_pio_pkg::*;

  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_s;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign sync_o   = sync_s;
  assign stable_o = stable_q;

  // Next state: shift the synchroniser; count consecutive disagreeing cycles
  // and only adopt the new level once the full window has elapsed.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/rlc_switch_pio_irq.sv
// Avalon-MM input PIO with per-bit debounce, edge capture (W1C) and a
// maskable level interrupt. Serves both the board switches and pushbuttons.
module rlc_switch_pio_irq #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  import rlc_pio_pkg::*;

  logic [WIDTH-1:0] raw_s, stable_s, edge_ev;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_ok;

  // Bits of writedata above WIDTH are intentionally dropped.
  assign unused_ok = &{1'b0, writedata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    rlc_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .sync_o  (raw_s[i]),
      .stable_o(stable_s[i])
    );
  end

  assign wr_en    = chipselect & ~write_n;
  assign irq      = |(edgecap_q & irqmask_q);
  assign readdata = readdata_q;

  // Edge event selection against the previous debounced value.
  always_comb begin
    edge_ev = stable_s & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_ev = ~stable_s & prev_q;
      EDGE_ANY:     edge_ev = stable_s ^ prev_q;
      default:      edge_ev = stable_s & ~prev_q;
    endcase
  end

  // Register updates; a new edge event overrides a same-cycle W1C clear.
  always_comb begin
    prev_d    = stable_s;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_ev;
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(stable_s);
      ADDR_RAW:     readdata_d = 32'(raw_s);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= prev_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_rlc_switch_pio_irq.sv
// Directed bench for rlc_switch_pio_irq: three instances (rising, falling,
// any edge) share one bus and input port so edge modes are compared side by side.
module tb_rlc_switch_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_rise, rd_fall, rd_any;
  logic        irq_rise, irq_fall, irq_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rlc_switch_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_port), .irq(irq_rise));

  rlc_switch_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
    .in_port(in_port), .irq(irq_fall));

  rlc_switch_pio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    step(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;
    step(3);
    chk("reset_readdata", rd_rise, 32'h0);
    chk("reset_irq", 32'(irq_rise), 32'h0);
    reset_n = 1'b1;

    // Idle reads of every register
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk($sformatf("idle_read_addr%0d", a), rd_rise, 32'h0);
    end
    chk("idle_irq", 32'(irq_rise), 32'h0);

    // Debounce pass on bit 0 (in_port changes just after edge N)
    address = 2'd1;
    in_port = 8'h01;
    step(2);
    chk("raw_not_yet_N2", rd_rise, 32'h0);
    step(1);
    chk("raw_seen_N3", rd_rise, 32'h1);
    address = 2'd0;
    step(3);
    chk("data_not_yet_N6", rd_rise, 32'h0);
    step(1);
    chk("data_seen_N7", rd_rise, 32'h1);
    address = 2'd3;
    step(1);
    chk("edgecap_rise_N8", rd_rise, 32'h1);
    chk("edgecap_fall_no_rise", rd_fall, 32'h0);
    chk("edgecap_any_rise", rd_any, 32'h1);
    chk("irq_masked_off", 32'(irq_rise), 32'h0);
    wr(2'd3, 32'hFF);

    // Glitch on bit 3 for three sampled cycles
    address = 2'd1;
    in_port = 8'h09;
    step(3);
    chk("glitch_raw", rd_rise, 32'h9);
    in_port = 8'h01;
    step(8);
    rd(2'd0);
    chk("glitch_data", rd_rise, 32'h1);
    rd(2'd3);
    chk("glitch_edgecap", rd_rise, 32'h0);
    chk("glitch_edgecap_any", rd_any, 32'h0);
    chk("glitch_irq", 32'(irq_rise), 32'h0);

    // Interrupt mask and W1C
    wr(2'd2, 32'hABCDEF05);
    rd(2'd2);
    chk("irqmask_readback", rd_rise, 32'h5);
    in_port = 8'h00;
    step(8);
    wr(2'd3, 32'hFF);
    in_port = 8'h03;
    step(6);
    chk("irq_before_edgecap", 32'(irq_rise), 32'h0);
    step(1);
    chk("irq_with_edgecap", 32'(irq_rise), 32'h1);
    rd(2'd3);
    chk("edgecap_bits01", rd_rise, 32'h3);
    wr(2'd3, 32'h1);
    chk("w1c_read_preclear", rd_rise, 32'h3);
    chk("irq_after_clear0", 32'(irq_rise), 32'h0);
    rd(2'd3);
    chk("edgecap_after_clear0", rd_rise, 32'h2);
    wr(2'd3, 32'h2);
    rd(2'd3);
    chk("edgecap_after_clear1", rd_rise, 32'h0);

    // Set wins over a same-cycle clear on bit 2 (event lands at edge C+7)
    in_port = 8'h07;
    step(6);
    address    = 2'd3;
    writedata  = 32'h4;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(2'd3);
    chk("collision_edgecap", rd_rise, 32'h4);
    chk("collision_irq", 32'(irq_rise), 32'h1);

    // Edge modes on bit 7
    wr(2'd3, 32'hFF);
    in_port = 8'h87;
    step(9);
    rd(2'd3);
    chk("b7_rise_rising", rd_rise, 32'h80);
    chk("b7_rise_falling", rd_fall, 32'h0);
    chk("b7_rise_any", rd_any, 32'h80);
    wr(2'd3, 32'hFF);
    in_port = 8'h07;
    step(9);
    rd(2'd3);
    chk("b7_fall_rising", rd_rise, 32'h0);
    chk("b7_fall_falling", rd_fall, 32'h80);
    chk("b7_fall_any", rd_any, 32'h80);
    chk("b7_fall_irq_unmasked", 32'(irq_fall), 32'h0);

    // Reset in the middle of a debounce count on bit 4
    reset_n = 1'b0;
    in_port = 8'h00;
    step(2);
    reset_n = 1'b1;
    in_port = 8'h10;
    step(4);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(2);
    in_port = 8'h00;
    step(10);
    rd(2'd0);
    chk("midreset_data", rd_rise, 32'h0);
    rd(2'd3);
    chk("midreset_edgecap", rd_any, 32'h0);
    rd(2'd2);
    chk("midreset_irqmask", rd_rise, 32'h0);
    chk("midreset_irq", 32'(irq_rise), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rlc_switch_pio_irq.md
# rlc_switch_pio_irq

Parametrised Avalon-MM input PIO for the RLC game system, replacing the fixed 8-bit switches PIO. Each input bit passes through a synchroniser, a per-bit debouncer and an edge detector. Per-bit edge-capture flags can be masked into a level interrupt. Sits on the Nios II data bus next to the other PIOs and serves both the board switches and the pushbuttons.

## Interface
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced value changes, ≥1.
- EDGE_TYPE, 0: captured edge; 0 rising, 1 falling, 2 any.
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data, zero-extended.
- in_port  in  WIDTH  asynchronous switch/button inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map:
  - 0 DATA (RO): debounced value.
  - 1 RAW (RO): synchronised, undebounced value.
  - 2 IRQMASK (RW): bits [WIDTH-1:0].
  - 3 EDGECAP (R/W1C): edge flags.
- Writes to 0/1 are ignored; writedata bits ≥WIDTH are ignored.
- Synchroniser: in_port shifts through SYNC_STAGES flops; the last stage is sync.
- Debouncer, per bit, with counter cnt of width clog2(DEBOUNCE_CYCLES)+1:
  - sync == stable: cnt←0.
  - sync != stable and cnt == DEBOUNCE_CYCLES-1: stable←sync, cnt←0.
  - otherwise: cnt←cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches stable.
- Edge detect: prev←stable every cycle. The edge event per bit is:
  - rising: stable&~prev.
  - falling: ~stable&prev.
  - any: stable^prev.
- EDGECAP[i]←1 on an edge event. It clears only on a write to address 3 with writedata[i]=1. If an event and a clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGECAP & IRQMASK), decoded combinationally from flops.
- readdata←mux(address) every clock, independent of chipselect; unused upper bits are 0.

## Timing
- Reset (reset_n low at a clk edge) clears the following to 0: sync chain, stable, prev, cnt, IRQMASK, EDGECAP, readdata. irq is therefore 0.
- Reset mid-debounce discards any partial count.
- Inputs that are high at reset release appear in DATA after SYNC_STAGES+DEBOUNCE_CYCLES cycles. With EDGE_TYPE 0 or 2 they also set EDGECAP; software clears EDGECAP after init.
- Latency from a pin change at edge N, input held stable:
  - RAW shows it at edge N+SYNC_STAGES.
  - stable updates at N+SYNC_STAGES+DEBOUNCE_CYCLES.
  - EDGECAP sets one edge later.
  - irq rises combinationally with EDGECAP.
- Read latency is 1: address presented at edge K gives readdata valid after edge K+1.
- A write takes effect at the edge where chipselect=1 and write_n=0. A read of the same register in the next cycle returns the new value.
- A read and a W1C write of EDGECAP in the same cycle return the pre-clear value.

## Structure
- Shared package rlc_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RAW=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY.
  - a clog2 helper.
- Sub-module rlc_debounce_bit (synchroniser + counter + stable flop for one bit, parameters SYNC_STAGES, DEBOUNCE_CYCLES). It is instantiated WIDTH times by a generate loop.
- Edge logic, registers and read mux live in the top module.

## Test plan
All scenarios use WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.
- Reset/idle: after reset with in_port=0x00, reads of addresses 0–3 return 0x00000000 and irq=0.
- Debounce pass: in_port[0] 0→1 at edge N.
  - RAW=0x01 by N+2.
  - DATA=0x01 at N+6.
  - EDGECAP=0x01 at N+7.
  - irq stays 0 with mask 0.
- Glitch reject: in_port[3] high for 3 cycles, then low. DATA, EDGECAP and irq stay 0; RAW briefly shows 0x08.
- Interrupt and W1C:
  - Write IRQMASK=0x05, then raise bits 0 and 1 → EDGECAP=0x03, irq=1.
  - Write 0x01 to address 3 → EDGECAP=0x02, irq=0.
  - Write 0x02 → EDGECAP=0x00.
- Set-vs-clear collision: a W1C of bit 2 in the same cycle as its edge event leaves EDGECAP[2]=1.
- Edge modes:
  - EDGE_TYPE=1: a 1→0 debounced transition on bit 7 sets EDGECAP=0x80; a 0→1 transition does not.
  - EDGE_TYPE=2: both transitions set EDGECAP.
  - Reset asserted mid-count clears cnt; DATA stays 0.
